decode_scoreboard_stage: RTL and testbench

Parametrised successor of the ID pipeline stage. It sits between the IF/ID latch and ID/EX and takes decoded control from unit_control and operands from bank_register. It replaces the one-deep load-use hazard check with a per-register latency scoreboard and N-source forwarding for early branch resolution. It also adds a valid/flush handshake and a halt-drain state machine.

---
 rtl/decode_scoreboard_stage_pkg.sv | 25 ++
 rtl/decode_scoreboard_stage_reg_scoreboard.sv | 64 ++++++
 rtl/decode_scoreboard_stage.sv | 201 ++++++++++++++++++++
 tb/tb_decode_scoreboard_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_stage_pkg.sv
// Shared definitions for the decode/scoreboard stage: instruction field
// positions, drain FSM encoding and the scoreboard counter sizing rule.
package decode_scoreboard_stage_pkg;

    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_LSB  = 0;
    localparam int FUNC_W    = 6;
    localparam int INM_LSB   = 0;
    localparam int INM_W     = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // A counter must hold the longest latency, which is the load latency.
    function automatic int sb_cnt_width(input int load_lat);
        return (load_lat < 1) ? 1 : $clog2(load_lat + 1);
    endfunction

endpackage

// File: rtl/decode_scoreboard_stage_reg_scoreboard.sv
// Per-register latency scoreboard: one down-counter per architectural
// register, loaded when a writer issues and drained once per enabled cycle.
module decode_scoreboard_stage_reg_scoreboard
    import decode_scoreboard_stage_pkg::*;
#(
    parameter int NB_REG   = 5,
    parameter int ALU_LAT  = 2,
    parameter int LOAD_LAT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load_en,
    input  logic [NB_REG-1:0] load_reg,
    input  logic              load_is_mem,
    input  logic [NB_REG-1:0] rs,
    input  logic [NB_REG-1:0] rt,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              all_clear
);

    localparam int N_REGS = 2 ** NB_REG;
    localparam int CNT_W  = sb_cnt_width(LOAD_LAT);
    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

    logic [CNT_W-1:0] count [N_REGS];

    // NOTE: these counters gate issue right after reset, so unlike a data
    // array they must be cleared; the loop resets every entry.
    // NOTE: sequential state uses <= so all counters update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < N_REGS; r++) begin
                count[r] <= '0;
            end
        end else if (enable) begin
            // Register 0 is never written, so its counter stays at zero.
            for (int r = 1; r < N_REGS; r++) begin
                if (load_en && load_reg == NB_REG'(r)) begin
                    count[r] <= load_is_mem ? LOAD_CNT : ALU_CNT;
                end else if (count[r] != '0) begin
                    count[r] <= count[r] - CNT_W'(1);
                end
            end
        end
    end

    assign busy_rs = (count[rs] != '0);
    assign busy_rt = (count[rt] != '0);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        all_clear = 1'b1;
        for (int r = 0; r < N_REGS; r++) begin
            if (count[r] != '0) begin
                all_clear = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decode_scoreboard_stage.sv
// ID stage with per-register latency scoreboard, N-source operand forwarding,
// early branch resolution and a halt-drain FSM feeding the ID/EX register.
module decode_scoreboard_stage
    import decode_scoreboard_stage_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_ADDR  = 32,
    parameter int N_FWD    = 2,
    parameter int ALU_LAT  = 2,
    parameter int LOAD_LAT = 3,
    parameter int NB_CTRL  = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic                     i_flush,
    input  logic [31:0]              i_instruction,
    input  logic [NB_ADDR-1:0]       i_pc,
    input  logic [NB_CTRL-1:0]       i_ctrl,
    input  logic                     i_is_load,
    input  logic                     i_reg_write,
    input  logic                     i_use_rs,
    input  logic                     i_use_rt,
    input  logic                     i_beq,
    input  logic                     i_bne,
    input  logic                     i_jump,
    input  logic                     i_jr,
    input  logic                     i_halt,
    input  logic [NB_REG-1:0]        i_dest,
    input  logic [NB_DATA-1:0]       i_data_ra,
    input  logic [NB_DATA-1:0]       i_data_rb,
    input  logic [N_FWD-1:0]         i_fwd_valid,
    input  logic [N_FWD*NB_REG-1:0]  i_fwd_reg,
    input  logic [N_FWD*NB_DATA-1:0] i_fwd_data,
    output logic                     o_valid,
    output logic [NB_CTRL-1:0]       o_ctrl,
    output logic [NB_REG-1:0]        o_rs,
    output logic [NB_REG-1:0]        o_rt,
    output logic [NB_REG-1:0]        o_dest,
    output logic [NB_REG-1:0]        o_shamt,
    output logic [5:0]               o_function,
    output logic [NB_DATA-1:0]       o_data_ra,
    output logic [NB_DATA-1:0]       o_data_rb,
    output logic [NB_DATA-1:0]       o_inm_ext,
    output logic                     o_pc_write,
    output logic                     o_IF_ID_write,
    output logic                     o_branch_taken,
    output logic [NB_ADDR-1:0]       o_target,
    output logic                     o_halt
);

    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  shamt;
    logic [FUNC_W-1:0]  func;
    logic [NB_DATA-1:0] inm_ext;
    logic [NB_DATA-1:0] op_a;
    logic [NB_DATA-1:0] op_b;
    logic               hit_a;
    logic               hit_b;
    logic               busy_rs;
    logic               busy_rt;
    logic               all_clear;
    logic               ready_rs;
    logic               ready_rt;
    logic               stall;
    logic               run;
    logic               go;
    logic               issue;
    logic               track_write;
    logic               eq;
    logic               take;
    state_t             state;

    assign rs      = i_instruction[RS_LSB +: NB_REG];
    assign rt      = i_instruction[RT_LSB +: NB_REG];
    assign shamt   = i_instruction[SHAMT_LSB +: NB_REG];
    assign func    = i_instruction[FUNC_LSB +: FUNC_W];
    assign inm_ext = NB_DATA'($signed(i_instruction[INM_LSB +: INM_W]));

    always_comb begin
        op_a  = i_data_ra;
        op_b  = i_data_rb;
        hit_a = 1'b0;
        hit_b = 1'b0;
        // Walk oldest to youngest so the lowest-index hit is the one that sticks.
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && rs != '0 && i_fwd_reg[k*NB_REG +: NB_REG] == rs) begin
                op_a  = i_fwd_data[k*NB_DATA +: NB_DATA];
                hit_a = 1'b1;
            end
            if (i_fwd_valid[k] && rt != '0 && i_fwd_reg[k*NB_REG +: NB_REG] == rt) begin
                op_b  = i_fwd_data[k*NB_DATA +: NB_DATA];
                hit_b = 1'b1;
            end
        end
    end

    decode_scoreboard_stage_reg_scoreboard #(
        .NB_REG   (NB_REG),
        .ALU_LAT  (ALU_LAT),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clock       (i_clock),
        .reset       (i_reset),
        .enable      (i_enable),
        .load_en     (track_write),
        .load_reg    (i_dest),
        .load_is_mem (i_is_load),
        .rs          (rs),
        .rt          (rt),
        .busy_rs     (busy_rs),
        .busy_rt     (busy_rt),
        .all_clear   (all_clear)
    );

    assign ready_rs    = ~i_use_rs | (rs == '0) | ~busy_rs | hit_a;
    assign ready_rt    = ~i_use_rt | (rt == '0) | ~busy_rt | hit_b;
    assign stall       = i_valid & (~ready_rs | ~ready_rt);
    assign run         = (state == RUN);
    assign go          = i_enable & i_valid & ~stall & ~i_flush & run;
    assign issue       = go & ~i_halt;
    assign track_write = issue & i_reg_write & (i_dest != '0);

    assign eq   = (op_a == op_b);
    assign take = go & ((i_beq & eq) | (i_bne & ~eq) | i_jump | i_jr);

    always_comb begin
        o_target = '0;
        if (take) begin
            if (i_jr) begin
                o_target = NB_ADDR'(op_a);
            end else if (i_jump) begin
                o_target = NB_ADDR'(i_instruction);
            end else begin
                o_target = i_pc + NB_ADDR'(inm_ext);
            end
        end
    end

    assign o_branch_taken = take;
    assign o_pc_write     = i_enable & ~stall & run & ~(i_valid & i_halt);
    assign o_IF_ID_write  = o_pc_write;

    // Halt is taken as a bubble, then the pipe drains until every pending write has landed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= RUN;
            o_halt <= 1'b0;
        end else if (i_enable) begin
            case (state)
                RUN: begin
                    if (go && i_halt) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (all_clear) begin
                        state  <= HALTED;
                        o_halt <= 1'b1;
                    end
                end
                HALTED: begin
                    o_halt <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid    <= 1'b0;
            o_ctrl     <= '0;
            o_rs       <= '0;
            o_rt       <= '0;
            o_dest     <= '0;
            o_shamt    <= '0;
            o_function <= '0;
            o_data_ra  <= '0;
            o_data_rb  <= '0;
            o_inm_ext  <= '0;
        end else if (i_enable) begin
            o_valid    <= issue;
            o_ctrl     <= issue ? i_ctrl : '0;
            o_rs       <= rs;
            o_rt       <= rt;
            o_dest     <= i_dest;
            o_shamt    <= shamt;
            o_function <= func;
            o_data_ra  <= op_a;
            o_data_rb  <= op_b;
            o_inm_ext  <= inm_ext;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard_stage.sv
// Randomized bench for decode_scoreboard_stage, checked against a model that
// tracks each register as "readable from enabled cycle N" plus directed cases.
module tb_decode_scoreboard_stage;

    localparam int NB_DATA  = 32;
    localparam int NB_REG   = 5;
    localparam int NB_ADDR  = 32;
    localparam int N_FWD    = 2;
    localparam int ALU_LAT  = 2;
    localparam int LOAD_LAT = 3;
    localparam int NB_CTRL  = 16;
    localparam int N_REGS   = 2 ** NB_REG;

    localparam int RUN_M    = 0;
    localparam int DRAIN_M  = 1;
    localparam int HALTED_M = 2;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic                     inst_valid;
    logic                     flush;
    logic [31:0]              instruction;
    logic [NB_ADDR-1:0]       pc;
    logic [NB_CTRL-1:0]       ctrl;
    logic                     is_load, reg_write, use_rs, use_rt;
    logic                     beq, bne, jump, jr, is_halt;
    logic [NB_REG-1:0]        dest;
    logic [NB_DATA-1:0]       data_ra, data_rb;
    logic [N_FWD-1:0]         fwd_valid;
    logic [N_FWD*NB_REG-1:0]  fwd_reg;
    logic [N_FWD*NB_DATA-1:0] fwd_data;

    logic                     ex_valid;
    logic [NB_CTRL-1:0]       ex_ctrl;
    logic [NB_REG-1:0]        ex_rs, ex_rt, ex_dest, ex_shamt;
    logic [5:0]               ex_function;
    logic [NB_DATA-1:0]       ex_data_ra, ex_data_rb, ex_inm_ext;
    logic                     pc_write, if_id_write, branch_taken;
    logic [NB_ADDR-1:0]       target;
    logic                     halted;

    // Reference model state.
    int                 cyc;
    int                 ready_at [N_REGS];
    int                 mstate;
    logic               e_valid, e_halt;
    logic [NB_CTRL-1:0] e_ctrl;
    logic [NB_REG-1:0]  e_rs, e_rt, e_dest, e_shamt;
    logic [5:0]         e_func;
    logic [NB_DATA-1:0] e_ra, e_rb, e_inm;

    int n_tests = 0;
    int n_fail  = 0;

    decode_scoreboard_stage #(
        .NB_DATA (NB_DATA), .NB_REG (NB_REG), .NB_ADDR (NB_ADDR), .N_FWD (N_FWD),
        .ALU_LAT (ALU_LAT), .LOAD_LAT (LOAD_LAT), .NB_CTRL (NB_CTRL)
    ) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_valid        (inst_valid),
        .i_flush        (flush),
        .i_instruction  (instruction),
        .i_pc           (pc),
        .i_ctrl         (ctrl),
        .i_is_load      (is_load),
        .i_reg_write    (reg_write),
        .i_use_rs       (use_rs),
        .i_use_rt       (use_rt),
        .i_beq          (beq),
        .i_bne          (bne),
        .i_jump         (jump),
        .i_jr           (jr),
        .i_halt         (is_halt),
        .i_dest         (dest),
        .i_data_ra      (data_ra),
        .i_data_rb      (data_rb),
        .i_fwd_valid    (fwd_valid),
        .i_fwd_reg      (fwd_reg),
        .i_fwd_data     (fwd_data),
        .o_valid        (ex_valid),
        .o_ctrl         (ex_ctrl),
        .o_rs           (ex_rs),
        .o_rt           (ex_rt),
        .o_dest         (ex_dest),
        .o_shamt        (ex_shamt),
        .o_function     (ex_function),
        .o_data_ra      (ex_data_ra),
        .o_data_rb      (ex_data_rb),
        .o_inm_ext      (ex_inm_ext),
        .o_pc_write     (pc_write),
        .o_IF_ID_write  (if_id_write),
        .o_branch_taken (branch_taken),
        .o_target       (target),
        .o_halt         (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] sext16(input logic [15:0] x);
        int v;
        v = int'(x);
        if (x[15]) v = v - 65536;
        return NB_DATA'(v);
    endfunction

    function automatic logic [31:0] mk(input int rs_f, input int rt_f, input logic [15:0] low);
        logic [31:0] w;
        w        = {6'h00, 10'h000, low};
        w[25:21] = 5'(rs_f);
        w[20:16] = 5'(rt_f);
        return w;
    endfunction

    // Youngest valid slot naming the register wins; register 0 never forwards.
    task automatic fwd_lookup(input int src, input logic [NB_DATA-1:0] dflt,
                              output logic [NB_DATA-1:0] val, output bit hit);
        val = dflt;
        hit = 1'b0;
        if (src != 0) begin
            for (int k = 0; k < N_FWD; k++) begin
                if (!hit && fwd_valid[k] && int'(fwd_reg[k*NB_REG +: NB_REG]) == src) begin
                    val = fwd_data[k*NB_DATA +: NB_DATA];
                    hit = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        mstate  = RUN_M;
        e_valid = 1'b0;
        e_halt  = 1'b0;
        e_ctrl  = '0;
        e_rs    = '0;
        e_rt    = '0;
        e_dest  = '0;
        e_shamt = '0;
        e_func  = '0;
        e_ra    = '0;
        e_rb    = '0;
        e_inm   = '0;
        for (int r = 0; r < N_REGS; r++) ready_at[r] = 0;
    endtask

    task automatic idle();
        reset       = 1'b0;
        enable      = 1'b1;
        inst_valid  = 1'b0;
        flush       = 1'b0;
        instruction = '0;
        pc          = '0;
        ctrl        = '0;
        is_load     = 1'b0;
        reg_write   = 1'b0;
        use_rs      = 1'b0;
        use_rt      = 1'b0;
        beq         = 1'b0;
        bne         = 1'b0;
        jump        = 1'b0;
        jr          = 1'b0;
        is_halt     = 1'b0;
        dest        = '0;
        data_ra     = '0;
        data_rb     = '0;
        fwd_valid   = '0;
        fwd_reg     = '0;
        fwd_data    = '0;
    endtask

    task automatic randomize_inputs();
        int flow;
        reset       = 1'b0;
        enable      = ($urandom_range(0, 9) != 0);
        inst_valid  = ($urandom_range(0, 7) != 0);
        flush       = ($urandom_range(0, 11) == 0);
        instruction = mk($urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
        pc          = NB_ADDR'($urandom);
        ctrl        = NB_CTRL'($urandom);
        is_load     = ($urandom_range(0, 3) == 0);
        reg_write   = ($urandom_range(0, 2) != 0);
        use_rs      = inst_valid && ($urandom_range(0, 1) == 1);
        use_rt      = inst_valid && ($urandom_range(0, 1) == 1);
        flow        = $urandom_range(0, 7);
        beq         = (flow == 1);
        bne         = (flow == 2);
        jump        = (flow == 3);
        jr          = (flow == 4);
        is_halt     = 1'b0;
        dest        = NB_REG'($urandom_range(0, 7));
        data_ra     = NB_DATA'($urandom_range(0, 3));
        data_rb     = NB_DATA'($urandom_range(0, 3));
        fwd_valid   = N_FWD'($urandom);
        for (int k = 0; k < N_FWD; k++) begin
            fwd_reg[k*NB_REG +: NB_REG]    = NB_REG'($urandom_range(0, 7));
            fwd_data[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom_range(0, 3));
        end
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic drive_cycle();
        logic [NB_DATA-1:0] a, b, imm;
        logic [NB_ADDR-1:0] tgt;
        bit hit_a, hit_b, ready_a, ready_b, stall_m, go, issue_m, taken_m, pcw, clear_m;
        int rs_i, rt_i;
        #1;
        rs_i = int'(instruction[25:21]);
        rt_i = int'(instruction[20:16]);
        fwd_lookup(rs_i, data_ra, a, hit_a);
        fwd_lookup(rt_i, data_rb, b, hit_b);
        ready_a = !use_rs || rs_i == 0 || cyc >= ready_at[rs_i] || hit_a;
        ready_b = !use_rt || rt_i == 0 || cyc >= ready_at[rt_i] || hit_b;
        stall_m = inst_valid && !(ready_a && ready_b);
        go      = enable && inst_valid && !stall_m && !flush && mstate == RUN_M;
        issue_m = go && !is_halt;
        taken_m = go && ((beq && a == b) || (bne && a != b) || jump || jr);
        imm     = sext16(instruction[15:0]);
        tgt     = '0;
        if (taken_m) begin
            if (jr)        tgt = a;
            else if (jump) tgt = instruction;
            else           tgt = pc + imm;
        end
        pcw = enable && !stall_m && mstate == RUN_M && !(inst_valid && is_halt);
        check("pc_write", pc_write, pcw);
        check("if_id_write", if_id_write, pcw);
        check("branch_taken", branch_taken, taken_m);
        check("target", target, tgt);
        clear_m = 1'b1;
        for (int r = 0; r < N_REGS; r++) if (cyc < ready_at[r]) clear_m = 1'b0;

        @(posedge clock);
        if (reset) begin
            model_reset();
        end else if (enable) begin
            e_valid = issue_m;
            e_ctrl  = issue_m ? ctrl : '0;
            e_rs    = instruction[25:21];
            e_rt    = instruction[20:16];
            e_dest  = dest;
            e_shamt = instruction[10:6];
            e_func  = instruction[5:0];
            e_ra    = a;
            e_rb    = b;
            e_inm   = imm;
            if (mstate == DRAIN_M && clear_m) begin
                mstate = HALTED_M;
                e_halt = 1'b1;
            end else if (mstate == RUN_M && go && is_halt) begin
                mstate = DRAIN_M;
            end
            cyc++;
            if (issue_m && reg_write && dest != 0)
                ready_at[dest] = cyc + (is_load ? LOAD_LAT : ALU_LAT);
        end
        #1;
        check("valid", ex_valid, e_valid);
        check("ctrl", ex_ctrl, e_ctrl);
        check("halt", halted, e_halt);
        if (e_valid) begin
            check("rs", ex_rs, e_rs);
            check("rt", ex_rt, e_rt);
            check("dest", ex_dest, e_dest);
            check("shamt", ex_shamt, e_shamt);
            check("function", ex_function, e_func);
            check("data_ra", ex_data_ra, e_ra);
            check("data_rb", ex_data_rb, e_rb);
            check("inm_ext", ex_inm_ext, e_inm);
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        drive_cycle();
        idle();
    endtask

    task automatic settle(input int n);
        idle();
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    initial begin
        int bubbles;
        int iters;

        idle();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        model_reset();
        drive_cycle();
        idle();
        check("reset_valid", ex_valid, 1'b0);
        check("reset_ctrl", ex_ctrl, '0);
        check("reset_data_ra", ex_data_ra, '0);
        check("reset_halt", halted, 1'b0);

        // Dependent ALU pair, second one fed by slot 0.
        settle(1);
        inst_valid = 1'b1; instruction = mk(1, 2, 16'h0000); use_rs = 1'b1; use_rt = 1'b1;
        reg_write = 1'b1; dest = 5'd3; ctrl = 16'h1234;
        drive_cycle();
        instruction = mk(3, 2, 16'h0000); dest = 5'd4; data_ra = 32'h0;
        fwd_valid = 2'b01; fwd_reg[4:0] = 5'd3; fwd_data[31:0] = 32'h55;
        drive_cycle();
        check("dep_alu_valid", ex_valid, 1'b1);
        check("dep_alu_ra", ex_data_ra, 32'h55);

        // Load-use without forwarding.
        settle(4);
        inst_valid = 1'b1; instruction = mk(1, 0, 16'h0004); use_rs = 1'b1;
        reg_write = 1'b1; is_load = 1'b1; dest = 5'd5;
        drive_cycle();
        instruction = mk(5, 2, 16'h0000); use_rt = 1'b1; is_load = 1'b0; dest = 5'd6;
        bubbles = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle();
            if (ex_valid) break;
            bubbles++;
        end
        check("load_use_bubbles", bubbles, LOAD_LAT);

        // beq resolved in ID with rs forwarded.
        settle(4);
        inst_valid = 1'b1; instruction = mk(1, 2, 16'hFFFC); use_rs = 1'b1; use_rt = 1'b1;
        beq = 1'b1; pc = 32'h10; data_ra = 32'h3; data_rb = 32'h7;
        fwd_valid = 2'b01; fwd_reg[4:0] = 5'd1; fwd_data[31:0] = 32'h7;
        #1;
        check("beq_taken", branch_taken, 1'b1);
        check("beq_target", target, 32'h0C);
        drive_cycle();

        // Both slots hit rs: slot 0 wins.
        settle(1);
        inst_valid = 1'b1; instruction = mk(4, 0, 16'h0000); use_rs = 1'b1;
        fwd_valid = 2'b11; fwd_reg[4:0] = 5'd4; fwd_reg[9:5] = 5'd4;
        fwd_data[31:0] = 32'hA; fwd_data[63:32] = 32'hB;
        drive_cycle();
        check("fwd_priority", ex_data_ra, 32'hA);

        // Halt behind a load: drain, then halt for good.
        settle(4);
        inst_valid = 1'b1; instruction = mk(1, 0, 16'h0000); use_rs = 1'b1;
        reg_write = 1'b1; is_load = 1'b1; dest = 5'd7;
        drive_cycle();
        idle();
        inst_valid = 1'b1; is_halt = 1'b1;
        drive_cycle();
        check("halt_is_bubble", ex_valid, 1'b0);
        idle();
        iters = 0;
        for (int i = 0; i < 20 && !halted; i++) begin
            #1;
            check("drain_pc_write", pc_write, 1'b0);
            drive_cycle();
            iters++;
        end
        check("halt_reached", halted, 1'b1);
        check("drain_cycles", iters, LOAD_LAT);
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            enable = 1'b1;
            #1;
            check("halted_pc_write", pc_write, 1'b0);
            drive_cycle();
            check("halted_bubble", ex_valid, 1'b0);
        end

        // Reset while draining.
        do_reset();
        inst_valid = 1'b1; instruction = mk(1, 0, 16'h0000); use_rs = 1'b1;
        reg_write = 1'b1; is_load = 1'b1; dest = 5'd7;
        drive_cycle();
        idle();
        inst_valid = 1'b1; is_halt = 1'b1;
        drive_cycle();
        do_reset();
        check("drain_reset_halt", halted, 1'b0);
        inst_valid = 1'b1; instruction = mk(7, 0, 16'h0000); use_rs = 1'b1;
        #1;
        check("drain_reset_ready", pc_write, 1'b1);
        drive_cycle();
        check("drain_reset_issue", ex_valid, 1'b1);

        // Randomized traffic against the model.
        settle(1);
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            drive_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
